// File: rtl/scan_chain_loader.sv
// Scan-chain configuration loader: accepts words over valid/ready, shifts them MSB-first
// onto the chain with a generated shift clock. Tail readback is built when SCAN_READBACK_EN is defined.
module scan_chain_loader #(
    parameter int unsigned CHAIN_LEN = 64,
    parameter int unsigned WORD_W    = 8
) (
    input  logic              ctrl_clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              scan_clk,
    output logic              scan_out,
    input  logic              scan_in,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    localparam int unsigned CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int unsigned WB_W  = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [WORD_W-1:0] r_shift;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [WB_W-1:0]   r_word_bits;
    logic              r_in_ready;
    logic              r_scan_clk;
    logic              r_scan_out;
    logic              r_busy;
    logic              r_done;

    logic [WORD_W-1:0] w_shift_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [WB_W-1:0]   w_word_bits_nxt;
    logic              w_last_bit;
    logic              w_word_end;

    assign w_shift_nxt     = r_shift << 1;
    assign w_bit_cnt_nxt   = r_bit_cnt + CNT_W'(1);
    assign w_word_bits_nxt = r_word_bits + WB_W'(1);
    assign w_last_bit      = (w_bit_cnt_nxt == CNT_W'(CHAIN_LEN));
    assign w_word_end      = (w_word_bits_nxt == WB_W'(WORD_W));

    // Main sequencer; scan_out is updated only on entry to SHIFT_LO so it is stable across the scan_clk high phase.
    always_ff @(posedge ctrl_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_word_bits <= '0;
            r_in_ready  <= 1'b0;
            r_scan_clk  <= 1'b0;
            r_scan_out  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_bit_cnt  <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (in_valid && r_in_ready) begin
                        r_state     <= S_SHIFT_LO;
                        r_shift     <= in_data;
                        r_word_bits <= '0;
                        r_scan_out  <= in_data[WORD_W-1];
                        r_in_ready  <= 1'b0;
                    end
                end
                S_SHIFT_LO: begin
                    r_state    <= S_SHIFT_HI;
                    r_scan_clk <= 1'b1;
                end
                S_SHIFT_HI: begin
                    r_scan_clk  <= 1'b0;
                    r_bit_cnt   <= w_bit_cnt_nxt;
                    r_word_bits <= w_word_bits_nxt;
                    r_shift     <= w_shift_nxt;
                    if (w_last_bit) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else if (w_word_end) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_state    <= S_SHIFT_LO;
                        r_scan_out <= w_shift_nxt[WORD_W-1];
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_scan_clk <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = r_in_ready;
    assign scan_clk = r_scan_clk;
    assign scan_out = r_scan_out;
    assign busy     = r_busy;
    assign done     = r_done;

`ifdef SCAN_READBACK_EN
    logic [WORD_W-1:0] r_rb_shift;
    logic [WORD_W-1:0] r_rb_data;
    logic              r_rb_valid;
    logic [WORD_W-1:0] w_rb_shift_nxt;

    assign w_rb_shift_nxt = (r_rb_shift << 1) | WORD_W'(scan_in);

    // Tail is sampled in SHIFT_LO, before the chain sees this bit's capture edge.
    always_ff @(posedge ctrl_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb_shift <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (r_state == S_SHIFT_LO) begin
                r_rb_shift <= w_rb_shift_nxt;
                if (r_word_bits == WB_W'(WORD_W - 1)) begin
                    r_rb_data  <= w_rb_shift_nxt;
                    r_rb_valid <= 1'b1;
                end
            end else if (r_state == S_SHIFT_HI && w_last_bit && !w_word_end) begin
                // Partial final word: left-align, stale upper bits shift out and zeros fill the bottom.
                r_rb_data  <= r_rb_shift << (WORD_W - 32'(w_word_bits_nxt));
                r_rb_valid <= 1'b1;
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`else
    logic w_unused_scan_in;
    assign w_unused_scan_in = scan_in;
    assign rb_data          = '0;
    assign rb_valid         = 1'b0;
`endif

endmodule

// File: tb/tb_scan_chain_loader.sv
// Directed bench for scan_chain_loader: a 64-bit default instance and a 10-bit partial-word instance,
// each driving a behavioral chain model. Readback checks are active when SCAN_READBACK_EN is defined.
module tb_scan_chain_loader;
    logic       ctrl_clk;
    logic       rst_n;
    logic       start, in_valid, in_ready, scan_clk, scan_out, scan_in, busy, done, rb_valid;
    logic [7:0] in_data, rb_data;
    logic       p_start, p_in_valid, p_in_ready, p_scan_clk, p_scan_out, p_scan_in, p_busy, p_done, p_rb_valid;
    logic [7:0] p_in_data, p_rb_data;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          edges    = 0;
    int          p_edges  = 0;
    int          rb_cnt   = 0;
    logic [63:0] chain    = '0;
    logic [9:0]  p_chain  = '0;
    logic [7:0]  rb_arr [64];

    scan_chain_loader #(.CHAIN_LEN(64), .WORD_W(8)) u_dut (
        .ctrl_clk(ctrl_clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .scan_clk(scan_clk), .scan_out(scan_out), .scan_in(scan_in),
        .busy(busy), .done(done), .rb_data(rb_data), .rb_valid(rb_valid)
    );

    scan_chain_loader #(.CHAIN_LEN(10), .WORD_W(8)) u_dut_p (
        .ctrl_clk(ctrl_clk), .rst_n(rst_n), .start(p_start), .in_data(p_in_data), .in_valid(p_in_valid),
        .in_ready(p_in_ready), .scan_clk(p_scan_clk), .scan_out(p_scan_out), .scan_in(p_scan_in),
        .busy(p_busy), .done(p_done), .rb_data(p_rb_data), .rb_valid(p_rb_valid)
    );

    initial ctrl_clk = 1'b0;
    always #5 ctrl_clk = ~ctrl_clk;

    // Behavioral chains: first flop takes scan_out, last flop drives scan_in.
    always @(posedge scan_clk) begin
        edges <= edges + 1;
        chain <= {chain[62:0], scan_out};
    end
    always @(posedge p_scan_clk) begin
        p_edges <= p_edges + 1;
        p_chain <= {p_chain[8:0], p_scan_out};
    end
    assign scan_in   = chain[63];
    assign p_scan_in = p_chain[9];

    always @(negedge ctrl_clk) begin
        if (rb_valid === 1'b1 && rb_cnt < 64) begin
            rb_arr[rb_cnt] <= rb_data;
            rb_cnt         <= rb_cnt + 1;
        end
    end

    // One full pass on the 64-bit instance; cycle 1 is the cycle start is presented.
    task automatic run_pass(input logic [63:0] pat, input int stall_word, input int stall_len,
                            input int busy_start_cyc, output int lat, output int words,
                            output int stall_cycles, output int stall_bad);
        int stall;
        bit hs;
        lat = 0; words = 0; stall = 0; stall_cycles = 0; stall_bad = 0;
        @(negedge ctrl_clk);
        start = 1'b1; in_valid = 1'b1; in_data = pat[63:56];
        for (int cyc = 2; cyc < 400; cyc++) begin
            hs = in_valid && in_ready;
            @(negedge ctrl_clk);
            start = (cyc == busy_start_cyc);
            if (hs) begin
                words++;
                if (words == stall_word) stall = stall_len;
            end
            if (done === 1'b1) begin
                lat = cyc;
                break;
            end
            if (words >= 8) begin
                in_valid = 1'b1;
                in_data  = 8'hEE;
            end else if (in_ready === 1'b1 && stall > 0) begin
                in_valid = 1'b0;
                stall--;
                stall_cycles++;
                if (scan_clk !== 1'b0) stall_bad++;
            end else begin
                in_valid = 1'b1;
                in_data  = pat[63-8*words -: 8];
            end
        end
        start = 1'b0; in_valid = 1'b0;
    endtask

    task automatic test_reset();
        int  e0;
        bit  hi_seen;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        p_start = 1'b0; p_in_valid = 1'b0; p_in_data = '0;
        repeat (3) @(negedge ctrl_clk);
        n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (scan_clk !== 1'b0) $display("FAIL rst_scan_clk: got %b want 0", scan_clk); else n_pass++;
        n_checks++; if (scan_out !== 1'b0) $display("FAIL rst_scan_out: got %b want 0", scan_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
        n_checks++; if (rb_data !== 8'h00) $display("FAIL rst_rb_data: got %h want 00", rb_data); else n_pass++;
        n_checks++; if (rb_valid !== 1'b0) $display("FAIL rst_rb_valid: got %b want 0", rb_valid); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge ctrl_clk);
        // Start a pass and yank reset while scan_clk is high.
        e0 = edges;
        start = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        @(negedge ctrl_clk);
        start = 1'b0;
        hi_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (scan_clk === 1'b1 && (edges - e0) >= 3) begin
                hi_seen = 1'b1;
                break;
            end
            @(negedge ctrl_clk);
        end
        n_checks++; if (hi_seen !== 1'b1) $display("FAIL mid_reached_shift_hi: got %b want 1", hi_seen); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (scan_clk !== 1'b0) $display("FAIL mid_rst_scan_clk: got %b want 0", scan_clk); else n_pass++;
        n_checks++; if (scan_out !== 1'b0) $display("FAIL mid_rst_scan_out: got %b want 0", scan_out); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b0) $display("FAIL mid_rst_in_ready: got %b want 0", in_ready); else n_pass++;
        n_checks++; if (done !== 1'b0 || rb_valid !== 1'b0)
            $display("FAIL mid_rst_pulses: got done=%b rb_valid=%b want 0 0", done, rb_valid); else n_pass++;
        e0 = edges;
        repeat (2) @(negedge ctrl_clk);
        rst_n = 1'b1;
        repeat (4) @(negedge ctrl_clk);
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL post_rst_idle: got busy=%b in_ready=%b want 0 0", busy, in_ready); else n_pass++;
        n_checks++; if (edges !== e0) $display("FAIL post_rst_edges: got %0d want %0d", edges, e0); else n_pass++;
        in_valid = 1'b0;
        @(negedge ctrl_clk);
    endtask

    task automatic test_default_pass();
        int lat, words, sc, sb, e0, r0;
        e0 = edges; r0 = rb_cnt;
        run_pass(64'hA53C960FF0817E5A, 99, 0, 40, lat, words, sc, sb);
        n_checks++; if (lat !== 138) $display("FAIL dflt_latency: got %0d want 138", lat); else n_pass++;
        n_checks++; if (edges - e0 !== 64) $display("FAIL dflt_edges: got %0d want 64", edges - e0); else n_pass++;
        n_checks++; if (chain !== 64'hA53C960FF0817E5A)
            $display("FAIL dflt_bits: got %h want a53c960ff0817e5a", chain); else n_pass++;
        n_checks++; if (words !== 8) $display("FAIL dflt_words: got %0d want 8", words); else n_pass++;
        @(negedge ctrl_clk);
        n_checks++; if (done !== 1'b0 || busy !== 1'b0)
            $display("FAIL dflt_after_done: got done=%b busy=%b want 0 0", done, busy); else n_pass++;
        repeat (3) @(negedge ctrl_clk);
        n_checks++; if (busy !== 1'b0) $display("FAIL dflt_no_restart: got busy=%b want 0", busy); else n_pass++;
`ifndef SCAN_READBACK_EN
        n_checks++; if (rb_cnt !== r0 || rb_data !== 8'h00)
            $display("FAIL dflt_no_readback: got pulses=%0d data=%h want 0 00", rb_cnt - r0, rb_data); else n_pass++;
`endif
    endtask

    task automatic test_stall();
        int lat, words, sc, sb, e0;
        e0 = edges;
        run_pass(64'hC35A0FF06996E11E, 3, 5, 0, lat, words, sc, sb);
        n_checks++; if (lat !== 143) $display("FAIL stall_latency: got %0d want 143", lat); else n_pass++;
        n_checks++; if (edges - e0 !== 64) $display("FAIL stall_edges: got %0d want 64", edges - e0); else n_pass++;
        n_checks++; if (chain !== 64'hC35A0FF06996E11E)
            $display("FAIL stall_bits: got %h want c35a0ff06996e11e", chain); else n_pass++;
        n_checks++; if (sc !== 5) $display("FAIL stall_ready_cycles: got %0d want 5", sc); else n_pass++;
        n_checks++; if (sb !== 0) $display("FAIL stall_scan_clk_low: got %0d high cycles want 0", sb); else n_pass++;
        repeat (2) @(negedge ctrl_clk);
    endtask

    task automatic test_partial(input logic [7:0] w0, input logic [7:0] w1, input logic [9:0] exp_chain);
        int  lat, words, e0, e_done;
        bit  hs;
        lat = 0; words = 0; e0 = p_edges; e_done = 0;
        @(negedge ctrl_clk);
        p_start = 1'b1; p_in_valid = 1'b1; p_in_data = w0;
        for (int cyc = 2; cyc < 200; cyc++) begin
            hs = p_in_valid && p_in_ready;
            @(negedge ctrl_clk);
            p_start = 1'b0;
            if (hs) words++;
            if (p_done === 1'b1) begin
                lat = cyc;
                e_done = p_edges - e0;
                break;
            end
            p_in_data = (words == 0) ? w0 : w1;
        end
        p_in_valid = 1'b0;
        n_checks++; if (lat !== 24) $display("FAIL part_latency: got %0d want 24", lat); else n_pass++;
        n_checks++; if (e_done !== 10) $display("FAIL part_edges_at_done: got %0d want 10", e_done); else n_pass++;
        n_checks++; if (p_chain !== exp_chain) $display("FAIL part_bits: got %h want %h", p_chain, exp_chain); else n_pass++;
        n_checks++; if (p_chain[1:0] !== exp_chain[1:0])
            $display("FAIL part_last_two: got %b want %b", p_chain[1:0], exp_chain[1:0]); else n_pass++;
        n_checks++; if (words !== 2) $display("FAIL part_words: got %0d want 2", words); else n_pass++;
        repeat (2) @(negedge ctrl_clk);
        n_checks++; if (p_edges - e0 !== 10) $display("FAIL part_edges_total: got %0d want 10", p_edges - e0); else n_pass++;
    endtask

`ifdef SCAN_READBACK_EN
    task automatic test_readback();
        int          lat, words, sc, sb, r0;
        logic [63:0] got;
        run_pass(64'h0123456789ABCDEF, 99, 0, 0, lat, words, sc, sb);
        repeat (2) @(negedge ctrl_clk);
        r0 = rb_cnt;
        run_pass(64'h5AA5F00F3CC3E7D2, 99, 0, 0, lat, words, sc, sb);
        repeat (2) @(negedge ctrl_clk);
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[55:0], rb_arr[r0+i]};
        n_checks++; if (rb_cnt - r0 !== 8) $display("FAIL rb1_pulses: got %0d want 8", rb_cnt - r0); else n_pass++;
        n_checks++; if (got !== 64'h0123456789ABCDEF) $display("FAIL rb1_data: got %h want 0123456789abcdef", got); else n_pass++;
        r0 = rb_cnt;
        run_pass(64'h1122334455667788, 99, 0, 0, lat, words, sc, sb);
        repeat (2) @(negedge ctrl_clk);
        got = '0;
        for (int i = 0; i < 8; i++) got = {got[55:0], rb_arr[r0+i]};
        n_checks++; if (rb_cnt - r0 !== 8) $display("FAIL rb2_pulses: got %0d want 8", rb_cnt - r0); else n_pass++;
        n_checks++; if (got !== 64'h5AA5F00F3CC3E7D2) $display("FAIL rb2_data: got %h want 5aa5f00f3cc3e7d2", got); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_default_pass();
        test_stall();
        test_partial(8'hFF, 8'hC0, 10'h3FF);
        test_partial(8'hA5, 8'h40, 10'h295);
`ifdef SCAN_READBACK_EN
        test_readback();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/scan_chain_loader.md
# scan_chain_loader

Serial configuration loader that sits directly upstream of the latch-based flop array's scan chain. It accepts configuration words over a valid/ready interface and serializes them MSB-first onto the chain's shift input. It also generates the chain's shift clock and signals completion after exactly CHAIN_LEN bits. Optionally, it captures the bits returning from the chain tail for readback.

## Interface
- CHAIN_LEN, 64: total scan-chain length in bits (≥1).
- WORD_W, 8: input/readback word width (≥1).

- ctrl_clk  in  1  block clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a load pass; sampled only in IDLE.
- in_data  in  WORD_W  configuration word, MSB shifted first.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- scan_clk  out  1  drives chain shift_clk; registered output.
- scan_out  out  1  drives shift_i of the first chain flop; registered output.
- scan_in  in  1  from shift_o of the last chain flop.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of pass.
- rb_data  out  WORD_W  readback word.
- rb_valid  out  1  one-cycle pulse, rb_data valid.

## Operation
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE.
- IDLE: start=1 → LOAD. The bit counter clears to 0.
- LOAD: in_ready=1. On in_valid&&in_ready, in_data is latched into the shift register and the state moves to SHIFT_LO. If in_valid stays low, the state holds in LOAD with scan_clk=0, which means the chain sees no edges while stalled.
- SHIFT_LO: scan_out = current MSB of the shift register; scan_clk=0; scan_in is sampled (readback). The state then moves to SHIFT_HI.
- SHIFT_HI: scan_clk=1, producing the chain's capture edge. The bit counter and shift register advance.
  - If the counter reaches CHAIN_LEN → DONE.
  - Else if WORD_W bits of the current word are consumed → LOAD.
  - Else → SHIFT_LO.
- DONE: done=1 for one cycle, then IDLE.
- Word count per pass = ceil(CHAIN_LEN/WORD_W). In the last word, only the top (CHAIN_LEN mod WORD_W) bits are shifted when the remainder is nonzero; its low bits are discarded.
- The bit counter is $clog2(CHAIN_LEN+1) bits wide and never wraps within a pass.
- start while busy is ignored. in_valid outside LOAD is ignored and no word is consumed.

## Timing
- Reset values: in_ready=0, scan_clk=0, scan_out=0, busy=0, done=0, rb_data=0, rb_valid=0. The state is IDLE.
- Reset is asynchronous mid-pass. scan_clk drops to 0 immediately and no further edges are produced. The partially written chain contents are undefined, and a fresh start is required.
- Cost per bit: 2 cycles. Each word adds ≥1 LOAD cycle.
- Minimum pass latency, start to done, with in_valid held high: 1 + words + 2·CHAIN_LEN + 1 cycles. This is 138 cycles for the defaults.
- scan_out is stable for a full cycle before and during scan_clk high, giving the chain setup time.
- busy rises the cycle after start is accepted. It falls the cycle after done.

## Configuration
- SCAN_READBACK_EN defined:
  - scan_in samples taken in SHIFT_LO are packed MSB-first into rb_data.
  - rb_valid pulses the cycle after the WORD_W-th sample of a word.
  - At pass end, a partial final word is emitted left-aligned, with zeros in the low bits. It pulses rb_valid in the DONE cycle.
  - The first CHAIN_LEN samples of a pass return the chain's previous contents.
- SCAN_READBACK_EN undefined: scan_in is ignored, and rb_data and rb_valid are tied to 0. No readback logic is present.

## Test plan
- Reset: hold rst_n=0 mid-SHIFT_HI → scan_clk=0 immediately and all outputs at their reset values. After release, the state stays IDLE until start.
- Default pass: start, then words 0xA5,0x3C,… with in_valid held high → scan_out sequence 1,0,1,0,0,1,0,1,0,0,1,1,… on successive scan_clk rising edges. Exactly 64 scan_clk edges occur and done pulses at cycle 138.
- Stall: deassert in_valid for 5 cycles before word 3 → in_ready high and scan_clk low throughout the stall. Total edges are still 64 and done is delayed by 5 cycles.
- Partial word, CHAIN_LEN=10, WORD_W=8, words 0xFF,0xC0 → 10 edges, last two bits 1,1, and done fires after the 10th edge.
- Ignored inputs: start during busy and in_valid during SHIFT states → no restart and no extra word consumed.
- Readback (SCAN_READBACK_EN): a behavioral 64-flop chain model preloaded with 0x0123456789ABCDEF, loaded with a new pattern → rb_data yields 0x01,0x23,…,0xEF with 8 rb_valid pulses. A second pass reads back the first pass's pattern.
